// File: rtl/game_state_ctrl.sv
// ---------------------------------------------------------------------------
// game_state_ctrl
//   Round/level sequencer between the collision checker and the frog, car and
//   seven-segment blocks. It tracks level and lives, holds the round reset
//   through death/win pauses and reports game over.
//
// Parameters
//   PAUSE_CYCLES : cycles a death/win pause lasts (minimum 1)
//   LIVES        : lives at game start (1..3)
//   MAX_LEVEL    : highest level value; the next win wraps to 0
//
// Ports
//   clk             in   system clock
//   reset           in   asynchronous active-high reset
//   death_collision in   frog overlaps a car (level signal)
//   win_collision   in   frog reached goal row (level signal)
//   restart_combo   in   all four switches pressed (level signal)
//   level           out  current level 0..MAX_LEVEL
//   lives           out  remaining lives 0..LIVES
//   round_reset     out  1 = frog and cars held at start positions
//   game_over       out  1 in GAME_OVER state
//   state           out  FSM encoding: 0 PLAY, 1 DEATH, 2 WIN, 3 GAME_OVER
//
// Build option
//   EXTRA_LIFE_EN : when defined, a win that wraps the level back to 0 also
//                   grants one life, saturating at 3.
// ---------------------------------------------------------------------------
module game_state_ctrl #(
    parameter int PAUSE_CYCLES = 12500000,
    parameter int LIVES        = 3,
    parameter int MAX_LEVEL    = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       death_collision,
    input  logic       win_collision,
    input  logic       restart_combo,
    output logic [3:0] level,
    output logic [1:0] lives,
    output logic       round_reset,
    output logic       game_over,
    output logic [1:0] state
);

    localparam int CNT_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_CYCLES - 1);

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        DEATH     = 2'd1,
        WIN       = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       level_d;
    logic [1:0]       lives_d;
    logic             round_reset_d;

    // One-flop input history for rising-edge detection.
    logic death_q, win_q, restart_q;
    logic death_rise, win_rise, restart_rise;

    assign death_rise   = death_collision & ~death_q;
    assign win_rise     = win_collision   & ~win_q;
    assign restart_rise = restart_combo   & ~restart_q;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= PLAY;
            count_q     <= '0;
            level       <= 4'd0;
            lives       <= 2'(LIVES);
            round_reset <= 1'b1;
            // History resets high so an input held across reset is not an edge.
            death_q     <= 1'b1;
            win_q       <= 1'b1;
            restart_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            level       <= level_d;
            lives       <= lives_d;
            round_reset <= round_reset_d;
            death_q     <= death_collision;
            win_q       <= win_collision;
            restart_q   <= restart_combo;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_d = state_q;
        count_d = count_q;
        level_d = level;
        lives_d = lives;

        if (restart_rise) begin
            // Restart beats every collision and starts a WIN-style pause.
            state_d = WIN;
            count_d = PAUSE_LAST;
            level_d = 4'd0;
            lives_d = 2'(LIVES);
        end else begin
            case (state_q)
                PLAY: begin
                    // Win is checked first: a simultaneous death costs no life.
                    if (win_rise) begin
                        state_d = WIN;
                        count_d = PAUSE_LAST;
                        if (level == 4'(MAX_LEVEL)) begin
                            level_d = 4'd0;
`ifdef EXTRA_LIFE_EN
                            lives_d = (lives == 2'd3) ? 2'd3 : lives + 2'd1;
`endif
                        end else begin
                            level_d = level + 4'd1;
                        end
                    end else if (death_rise) begin
                        state_d = DEATH;
                        count_d = PAUSE_LAST;
                        lives_d = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
                    end
                end
                DEATH, WIN: begin
                    // Counter runs PAUSE_CYCLES-1 down to 0: PAUSE_CYCLES cycles.
                    if (count_q == '0) begin
                        state_d = (lives == 2'd0) ? GAME_OVER : PLAY;
                    end else begin
                        count_d = count_q - CNT_W'(1);
                    end
                end
                GAME_OVER: begin
                    state_d = GAME_OVER;
                end
                default: begin
                    state_d = PLAY;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    // round_reset is registered from the next state so it is high from the
    // edge that starts a pause until the edge that returns to PLAY.
    always_comb begin
        round_reset_d = (state_d != PLAY);
        game_over     = (state_q == GAME_OVER);
        state         = state_q;
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_state_ctrl
//   Directed bench for game_state_ctrl with PAUSE_CYCLES=4, LIVES=3,
//   MAX_LEVEL=9. Inputs change and outputs are sampled 1 time unit after
//   each rising clock edge.
// ---------------------------------------------------------------------------
module tb_game_state_ctrl;

    logic       clk;
    logic       reset;
    logic       death_collision;
    logic       win_collision;
    logic       restart_combo;
    logic [3:0] level;
    logic [1:0] lives;
    logic       round_reset;
    logic       game_over;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

`ifdef EXTRA_LIFE_EN
    localparam int LIVES_AFTER_WRAP = 3;
`else
    localparam int LIVES_AFTER_WRAP = 2;
`endif

    game_state_ctrl #(
        .PAUSE_CYCLES(4),
        .LIVES       (3),
        .MAX_LEVEL   (9)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .death_collision(death_collision),
        .win_collision  (win_collision),
        .restart_combo  (restart_combo),
        .level          (level),
        .lives          (lives),
        .round_reset    (round_reset),
        .game_over      (game_over),
        .state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int lv, input int li,
                           input int rr, input int go);
        chk({tag, ".state"},       32'(state),       32'(st));
        chk({tag, ".level"},       32'(level),       32'(lv));
        chk({tag, ".lives"},       32'(lives),       32'(li));
        chk({tag, ".round_reset"}, 32'(round_reset), 32'(rr));
        chk({tag, ".game_over"},   32'(game_over),   32'(go));
    endtask

    task automatic pulse_win();
        win_collision = 1'b1;
        tick();
        win_collision = 1'b0;
    endtask

    task automatic pulse_death();
        death_collision = 1'b1;
        tick();
        death_collision = 1'b0;
    endtask

    task automatic pulse_restart();
        restart_combo = 1'b1;
        tick();
        restart_combo = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        death_collision = 1'b0;
        win_collision   = 1'b0;
        restart_combo   = 1'b0;

        // Reset values, then exactly one cycle of round_reset after release.
        repeat (2) tick();
        chk_all("reset", 0, 0, 3, 1, 0);
        reset = 1'b0;
        chk("release_hold.round_reset", 32'(round_reset), 32'd1);
        tick();
        chk_all("first_clk", 0, 0, 3, 0, 0);

        // Death held for 10 cycles: one decrement, 4-cycle pause.
        death_collision = 1'b1;
        tick();
        chk_all("death_edge", 1, 0, 2, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("death_pause.round_reset", 32'(round_reset), 32'd1);
        end
        tick();
        chk_all("death_done", 0, 0, 2, 0, 0);
        repeat (5) tick();
        chk_all("death_held", 0, 0, 2, 0, 0);
        death_collision = 1'b0;
        tick();

        // Two more deaths run lives to 0 and end in GAME_OVER.
        pulse_death();
        chk_all("death2", 1, 0, 1, 1, 0);
        repeat (4) tick();
        chk_all("death2_done", 0, 0, 1, 0, 0);
        pulse_death();
        chk_all("death3", 1, 0, 0, 1, 0);
        repeat (3) tick();
        chk("death3_last.state", 32'(state), 32'd1);
        tick();
        chk_all("game_over", 3, 0, 0, 1, 1);

        // A win edge in GAME_OVER changes nothing.
        pulse_win();
        tick();
        chk_all("go_win", 3, 0, 0, 1, 1);

        // Restart held high: one pause, no retrigger.
        restart_combo = 1'b1;
        tick();
        chk_all("restart", 2, 0, 3, 1, 0);
        repeat (3) tick();
        chk("restart_pause.round_reset", 32'(round_reset), 32'd1);
        tick();
        chk_all("restart_done", 0, 0, 3, 0, 0);
        repeat (2) tick();
        chk_all("restart_held", 0, 0, 3, 0, 0);
        restart_combo = 1'b0;
        tick();

        // Lose a life, then ten wins: level 1..9 then wrap to 0.
        pulse_death();
        repeat (4) tick();
        chk("pre_wins.lives", 32'(lives), 32'd2);
        for (int i = 1; i <= 10; i++) begin
            pulse_win();
            chk("win_step.level", 32'(level), 32'(i % 10));
            chk("win_step.state", 32'(state), 32'd2);
            repeat (4) tick();
        end
        chk("wrap_from2.lives", 32'(lives), 32'(LIVES_AFTER_WRAP));

        // A second full lap: lives saturate at 3 (or stay unchanged).
        for (int i = 1; i <= 10; i++) begin
            pulse_win();
            repeat (4) tick();
        end
        chk("lap2.level", 32'(level), 32'd0);
        chk("wrap_again.lives", 32'(lives), 32'(LIVES_AFTER_WRAP));

        // Back to level 4 with 3 lives, then simultaneous win and death.
        pulse_restart();
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            pulse_win();
            repeat (4) tick();
        end
        chk_all("pre_same", 0, 4, 3, 0, 0);
        death_collision = 1'b1;
        win_collision   = 1'b1;
        tick();
        death_collision = 1'b0;
        win_collision   = 1'b0;
        chk_all("same_cycle", 2, 5, 3, 1, 0);
        repeat (4) tick();
        chk_all("same_done", 0, 5, 3, 0, 0);

        // Reset mid-pause acts at once; death held across reset does not fire.
        death_collision = 1'b1;
        tick();
        tick();
        chk_all("mid_pause", 1, 5, 2, 1, 0);
        reset = 1'b1;
        #1;
        chk_all("async_reset", 0, 0, 3, 1, 0);
        tick();
        reset = 1'b0;
        tick();
        chk_all("post_reset", 0, 0, 3, 0, 0);
        death_collision = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
Round/level sequencer that sits directly downstream of the collision checker and upstream of the frog, car and seven-segment blocks.
- Inputs: death_collision, win_collision, the all-switches restart combo.
- Outputs: level number, remaining lives, a held round reset that parks frog and cars at their start positions during pauses, and game-over status.
- Replaces the ad-hoc posedge-win level counter in the top level; everything runs on clk.

Parameters:
PAUSE_CYCLES, 12500000, cycles a death/win pause lasts (0.5 s at 25 MHz); minimum 1
LIVES, 3, lives at game start; range 1..3
MAX_LEVEL, 9, highest level value; the next win wraps to 0

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
death_collision  input  1  frog overlaps a car; level signal, may stay high many cycles
win_collision  input  1  frog reached goal row; level signal
restart_combo  input  1  all four switches pressed; level signal
level  output  4  current level 0..MAX_LEVEL, feeds display_numbers
lives  output  2  remaining lives 0..LIVES
round_reset  output  1  high = frog and cars held at start positions
game_over  output  1  high in GAME_OVER state
state  output  2  FSM encoding, for debug/VGA: 0 PLAY, 1 DEATH, 2 WIN, 3 GAME_OVER

Behaviour:
- Reset is asynchronous: state=PLAY, level=0, lives=LIVES, round_reset=1, game_over=0, pause counter=0.
- First clock after reset release: round_reset=0.
- Collision inputs are rising-edge detected with a one-flop history; history flops reset to 1 so a collision held across reset does not fire.
- Event = rising edge seen that cycle; outputs are registered, so response appears one clk after the edge.
- PLAY:
  - win event -> WIN.
    - level <= level+1, or 0 when level==MAX_LEVEL.
    - round_reset <= 1; pause counter <= PAUSE_CYCLES-1.
  - death event -> DEATH.
    - lives <= lives-1; round_reset <= 1; counter <= PAUSE_CYCLES-1.
  - Win and death edges in the same cycle: win has priority; death is ignored, no life lost.
- DEATH and WIN:
  - round_reset held at 1; collision edges ignored.
  - Counter decrements each cycle.
  - At counter==0 next cycle:
    - if lives==0 -> GAME_OVER;
    - otherwise -> PLAY with round_reset=0.
  - Pause length is exactly PAUSE_CYCLES cycles of round_reset=1.
- GAME_OVER:
  - game_over=1, round_reset=1; level and lives frozen; collisions ignored.
- restart_combo rising edge, in any state, takes priority over every collision event:
  - level<=0, lives<=LIVES, state<=WIN-style pause of PAUSE_CYCLES, game_over<=0.
  - restart_combo held high does not retrigger.
- Arithmetic rules:
  - lives never underflows; a death decrement from 1 gives 0, then GAME_OVER after the pause.
  - level is stored at 4 bits; values above MAX_LEVEL are unreachable.
- Reset asserted mid-pause: immediate return to reset values; the counter is discarded.

Optional Feature:
EXTRA_LIFE_EN
- Defined: a win that wraps level MAX_LEVEL->0 also does lives <= min(lives+1, 3).
- Undefined: lives are never incremented except by restart_combo.

Test Plan:
Use PAUSE_CYCLES=4, LIVES=3, MAX_LEVEL=9.
- Reset then release -> level=0, lives=3, round_reset=1 for exactly one cycle, state=PLAY.
- death_collision high for 10 cycles -> lives=2 one cycle after the edge; round_reset=1 for 4 cycles; back to PLAY; no second decrement.
- Three separate deaths -> lives=0; after the third pause state=3, game_over=1, round_reset stays 1; a further win edge leaves level unchanged.
- Ten win edges -> level steps 1..9 then 0. With EXTRA_LIFE_EN and lives=2 at the wrap -> lives=3; with lives=3 -> stays 3.
- death and win rising in the same cycle at level=4, lives=3 -> level=5, lives=3, state=WIN.
- In GAME_OVER, pulse restart_combo -> next cycle game_over=0, level=0, lives=3; 4 cycles of round_reset; then PLAY. Asserting reset mid-pause returns all outputs to reset values immediately, without waiting for a clock.
